// File: rtl/ram_sched.sv
// DRAM cycle scheduler and refresh arbiter for the FSB main-memory controller.
// Every output is registered from the current state, so each strobe follows its state by one edge.
module ram_sched #(
    parameter int unsigned RAS_CYC = 2,
    parameter int unsigned CAS_CYC = 2,
    parameter int unsigned REF_CYC = 3,
    parameter int unsigned PRE_CYC = 2
) (
    input  logic CLK_FSB,
    input  logic nRES,
    input  logic BACT,
    input  logic RAMCS,
    input  logic nWE,
    input  logic nLDS,
    input  logic nUDS,
    input  logic RefReq,
    input  logic RefUrgent,
    output logic RefAck,
    output logic nRAS,
    output logic nCAS,
    output logic RASMux,
    output logic nRAMLWE,
    output logic nRAMUWE,
    output logic Ready
);

    localparam int unsigned MAX_AC  = (RAS_CYC > CAS_CYC) ? RAS_CYC : CAS_CYC;
    localparam int unsigned MAX_RP  = (REF_CYC > PRE_CYC) ? REF_CYC : PRE_CYC;
    localparam int unsigned MAX_CYC = (MAX_AC > MAX_RP) ? MAX_AC : MAX_RP;
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] RAS_LD = CW'(RAS_CYC);
    localparam logic [CW-1:0] CAS_LD = CW'(CAS_CYC);
    localparam logic [CW-1:0] REF_LD = CW'(REF_CYC);
    localparam logic [CW-1:0] PRE_LD = CW'(PRE_CYC);
    localparam logic [CW-1:0] ONE    = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        ACC_RAS,
        ACC_MUX,
        ACC_CAS,
        ACC_WAIT,
        REF_CAS,
        REF_RAS,
        PRE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          nras_q, nras_d;
    logic          ncas_q, ncas_d;
    logic          mux_q, mux_d;
    logic          lwe_q, lwe_d;
    logic          uwe_q, uwe_d;
    logic          rdy_q, rdy_d;
    logic          ack_q, ack_d;

    logic          last;
    logic          acc_req;

    assign last    = (cnt_q == ONE);
    assign acc_req = BACT && RAMCS;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (RefUrgent) begin
                    state_d = REF_CAS;
                end else if (acc_req) begin
                    state_d = ACC_RAS;
                    cnt_d   = RAS_LD;
                end else if (RefReq) begin
                    state_d = REF_CAS;
                end
            end
            ACC_RAS: begin
                if (!BACT) begin
                    state_d = PRE;
                    cnt_d   = PRE_LD;
                end else if (last) begin
                    state_d = ACC_MUX;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            ACC_MUX: begin
                if (!BACT) begin
                    state_d = PRE;
                    cnt_d   = PRE_LD;
                end else begin
                    state_d = ACC_CAS;
                    cnt_d   = CAS_LD;
                end
            end
            ACC_CAS: begin
                if (!BACT) begin
                    state_d = PRE;
                    cnt_d   = PRE_LD;
                end else if (last) begin
                    state_d = ACC_WAIT;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            ACC_WAIT: begin
                if (!BACT) begin
                    state_d = PRE;
                    cnt_d   = PRE_LD;
                end
            end
            REF_CAS: begin
                state_d = REF_RAS;
                cnt_d   = REF_LD;
            end
            REF_RAS: begin
                if (last) begin
                    state_d = PRE;
                    cnt_d   = PRE_LD;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            PRE: begin
                if (last) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            default: begin
                state_d = PRE;
                cnt_d   = PRE_LD;
            end
        endcase
    end

    // Ready and the write enables drop on the same edge BACT is seen low, ahead of the strobes.
    always_comb begin
        nras_d = !(state_q inside {ACC_RAS, ACC_MUX, ACC_CAS, ACC_WAIT, REF_RAS});
        ncas_d = !(state_q inside {ACC_CAS, ACC_WAIT, REF_CAS, REF_RAS});
        mux_d  = state_q inside {ACC_MUX, ACC_CAS, ACC_WAIT};
        ack_d  = (state_q == REF_CAS);
        rdy_d  = BACT && (((state_q == ACC_CAS) && last) || (state_q == ACC_WAIT));
        lwe_d  = 1'b1;
        uwe_d  = 1'b1;
        if (state_q == ACC_MUX && BACT) begin
            lwe_d = nWE | nLDS;
            uwe_d = nWE | nUDS;
        end else if ((state_q inside {ACC_CAS, ACC_WAIT}) && BACT) begin
            lwe_d = lwe_q;
            uwe_d = uwe_q;
        end
    end

    always_ff @(posedge CLK_FSB or negedge nRES) begin
        if (!nRES) begin
            state_q <= PRE;
            cnt_q   <= PRE_LD;
            nras_q  <= 1'b1;
            ncas_q  <= 1'b1;
            mux_q   <= 1'b0;
            lwe_q   <= 1'b1;
            uwe_q   <= 1'b1;
            rdy_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nras_q  <= nras_d;
            ncas_q  <= ncas_d;
            mux_q   <= mux_d;
            lwe_q   <= lwe_d;
            uwe_q   <= uwe_d;
            rdy_q   <= rdy_d;
            ack_q   <= ack_d;
        end
    end

    assign nRAS    = nras_q;
    assign nCAS    = ncas_q;
    assign RASMux  = mux_q;
    assign nRAMLWE = lwe_q;
    assign nRAMUWE = uwe_q;
    assign Ready   = rdy_q;
    assign RefAck  = ack_q;

endmodule
